// File: rtl/decoder3x8_stream.sv
// Registered streaming 3-to-8 one-hot (or one-cold) decoder.
// A 2-entry code FIFO absorbs back-pressure and a wrapping counter tallies output transfers.
module decoder3x8_stream #(
  parameter int unsigned CNT_W      = 16,
  parameter bit          ACTIVE_LOW = 1'b0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic [2:0]       in_code,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [7:0]       out,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             busy,
  output logic [CNT_W-1:0] dec_count
);

  localparam int unsigned CODE_W = 3;
  localparam int unsigned OUT_W  = 8;
  localparam int unsigned DEPTH  = 2;
  localparam int unsigned OCC_W  = 2;
  localparam logic [OUT_W-1:0] IDLE_WORD = ACTIVE_LOW ? 8'hFF : 8'h00;

  logic [CODE_W-1:0] mem_q [DEPTH];
  logic [CODE_W-1:0] mem_d [DEPTH];
  logic              head_q, head_d;
  logic              tail_q, tail_d;
  logic [OCC_W-1:0]  occ_q, occ_d;
  logic [CNT_W-1:0]  cnt_d;
  logic [OUT_W-1:0]  out_d;
  logic [CODE_W-1:0] head_code;
  logic [OUT_W-1:0]  onehot;
  logic              push, pop;

  // Acceptance never looks at out_ready, so a full buffer cannot push and pop together.
  assign in_ready = en && (occ_q < OCC_W'(DEPTH));
  assign push     = in_valid && in_ready;
  assign pop      = out_valid && out_ready;
  assign busy     = out_valid;

  // Next-state of the FIFO; out is pre-decoded from the post-update head.
  always_comb begin
    mem_d  = mem_q;
    head_d = head_q;
    tail_d = tail_q;
    occ_d  = occ_q;
    cnt_d  = dec_count;
    if (push) begin
      mem_d[tail_q] = in_code;
      tail_d        = ~tail_q;
    end
    if (pop) begin
      head_d = ~head_q;
      cnt_d  = dec_count + CNT_W'(1);
    end
    case ({push, pop})
      2'b10:   occ_d = occ_q + OCC_W'(1);
      2'b01:   occ_d = occ_q - OCC_W'(1);
      default: occ_d = occ_q;
    endcase
    head_code = mem_d[head_d];
    onehot    = OUT_W'(1) << head_code;
    if (occ_d == '0) begin
      out_d = IDLE_WORD;
    end else begin
      out_d = ACTIVE_LOW ? ~onehot : onehot;
    end
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      mem_q[0]  <= '0;
      mem_q[1]  <= '0;
      head_q    <= 1'b0;
      tail_q    <= 1'b0;
      occ_q     <= '0;
      dec_count <= '0;
      out       <= IDLE_WORD;
      out_valid <= 1'b0;
    end else begin
      mem_q[0]  <= mem_d[0];
      mem_q[1]  <= mem_d[1];
      head_q    <= head_d;
      tail_q    <= tail_d;
      occ_q     <= occ_d;
      dec_count <= cnt_d;
      out       <= out_d;
      out_valid <= (occ_d != '0);
    end
  end

endmodule

// File: tb/tb_decoder3x8_stream.sv
// Directed bench for decoder3x8_stream: default, one-cold and 4-bit-counter builds share one stimulus.
module tb_decoder3x8_stream;

  logic        clk = 1'b0;
  logic        rst_n, en, in_valid, out_ready;
  logic [2:0]  in_code;

  logic        in_ready, out_valid, busy;
  logic [7:0]  out;
  logic [15:0] dec_count;

  logic        in_ready_al, out_valid_al, busy_al;
  logic [7:0]  out_al;
  logic [15:0] dec_count_al;

  logic        in_ready_w4, out_valid_w4, busy_w4;
  logic [7:0]  out_w4;
  logic [3:0]  dec_count_w4;

  int compared   = 0;
  int mismatched = 0;

  logic [7:0] exp_seq [8];

  always #5 clk = ~clk;

  decoder3x8_stream #(.CNT_W(16), .ACTIVE_LOW(1'b0)) dut (
    .clk(clk), .rst_n(rst_n), .en(en), .in_code(in_code), .in_valid(in_valid),
    .in_ready(in_ready), .out(out), .out_valid(out_valid), .out_ready(out_ready),
    .busy(busy), .dec_count(dec_count)
  );

  decoder3x8_stream #(.CNT_W(16), .ACTIVE_LOW(1'b1)) dut_al (
    .clk(clk), .rst_n(rst_n), .en(en), .in_code(in_code), .in_valid(in_valid),
    .in_ready(in_ready_al), .out(out_al), .out_valid(out_valid_al), .out_ready(out_ready),
    .busy(busy_al), .dec_count(dec_count_al)
  );

  decoder3x8_stream #(.CNT_W(4), .ACTIVE_LOW(1'b0)) dut_w4 (
    .clk(clk), .rst_n(rst_n), .en(en), .in_code(in_code), .in_valid(in_valid),
    .in_ready(in_ready_w4), .out(out_w4), .out_valid(out_valid_w4), .out_ready(out_ready),
    .busy(busy_w4), .dec_count(dec_count_w4)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    compared++;
    assert (obs === expv) else begin
      mismatched++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  initial begin
    exp_seq = '{8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80};
    rst_n = 1'b0; en = 1'b1; in_valid = 1'b0; out_ready = 1'b1; in_code = 3'd0;
    step();
    step();

    // reset state
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_count", 32'(dec_count), 32'd0);
    check("rst_out", 32'(out), 32'h00);
    check("rst_out_al", 32'(out_al), 32'hFF);
    check("rst_in_ready", 32'(in_ready), 32'd1);
    rst_n = 1'b1;

    // codes 0..7 back to back, consumer always ready
    for (int i = 0; i < 8; i++) begin
      in_valid = 1'b1;
      in_code  = 3'(i);
      step();
      check($sformatf("seq_out_%0d", i), 32'(out), 32'(exp_seq[i]));
      check($sformatf("seq_valid_%0d", i), 32'(out_valid), 32'd1);
    end
    in_valid = 1'b0;
    step();
    check("seq_count", 32'(dec_count), 32'd8);
    check("seq_drained", 32'(out_valid), 32'd0);

    // back-pressure: 3 and 5 buffered, 6 refused until space frees
    out_ready = 1'b0;
    in_valid  = 1'b1; in_code = 3'd3;
    step();
    in_code = 3'd5;
    check("bp_ready_2nd", 32'(in_ready), 32'd1);
    step();
    in_code = 3'd6;
    check("bp_ready_full", 32'(in_ready), 32'd0);
    step();
    check("bp_hold_out", 32'(out), 32'h08);
    check("bp_hold_valid", 32'(out_valid), 32'd1);
    out_ready = 1'b1;
    step();
    check("bp_out_5", 32'(out), 32'h20);
    step();
    check("bp_out_6", 32'(out), 32'h40);
    in_valid = 1'b0;
    step();
    check("bp_count", 32'(dec_count), 32'd11);
    check("bp_empty", 32'(out_valid), 32'd0);

    // simultaneous push (2) and pop (7) at occupancy 1
    out_ready = 1'b0;
    in_valid  = 1'b1; in_code = 3'd7;
    step();
    check("sim_out_7", 32'(out), 32'h80);
    in_code = 3'd2; out_ready = 1'b1;
    step();
    check("sim_out_2", 32'(out), 32'h04);
    check("sim_out_al_2", 32'(out_al), 32'hFB);
    check("sim_ready", 32'(in_ready), 32'd1);
    check("sim_count", 32'(dec_count), 32'd12);
    in_valid = 1'b0;
    step();
    check("sim_empty_out", 32'(out), 32'h00);
    check("sim_empty_out_al", 32'(out_al), 32'hFF);

    // en=0 with two buffered entries: no pushes, both drain
    out_ready = 1'b0;
    in_valid  = 1'b1; in_code = 3'd4;
    step();
    in_code = 3'd1;
    step();
    check("en_out_al_4", 32'(out_al), 32'hEF);
    en = 1'b0; in_code = 3'd0;
    check("en_ready_off", 32'(in_ready), 32'd0);
    out_ready = 1'b1;
    step();
    check("en_drain_1", 32'(out), 32'h02);
    check("en_busy_mid", 32'(busy), 32'd1);
    step();
    check("en_busy_fall", 32'(busy), 32'd0);
    step();
    check("en_ignored", 32'(out_valid), 32'd0);
    check("en_count", 32'(dec_count), 32'd15);
    in_valid = 1'b0; en = 1'b1;

    // transfers 16 and 17: 4-bit counter wraps to 1
    in_valid = 1'b1; in_code = 3'd0;
    step();
    in_code = 3'd1;
    step();
    in_valid = 1'b0;
    step();
    check("wrap_count16", 32'(dec_count), 32'd17);
    check("wrap_count4", 32'(dec_count_w4), 32'd1);

    // reset with a full buffer discards it
    out_ready = 1'b0;
    in_valid  = 1'b1; in_code = 3'd5;
    step();
    in_code = 3'd6;
    step();
    check("full_busy", 32'(busy), 32'd1);
    rst_n = 1'b0; in_valid = 1'b0;
    step();
    check("mid_rst_valid", 32'(out_valid), 32'd0);
    check("mid_rst_count", 32'(dec_count), 32'd0);
    check("mid_rst_count4", 32'(dec_count_w4), 32'd0);
    check("mid_rst_out", 32'(out), 32'h00);
    check("mid_rst_out_al", 32'(out_al), 32'hFF);
    check("mid_rst_ready", 32'(in_ready), 32'd1);
    rst_n = 1'b1; out_ready = 1'b1;
    step();
    check("post_rst_empty", 32'(out_valid), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
